// File: rtl/instruction_fetch_unit.sv
// Purpose : owns the PC, fetches 32-bit words from imem and hands {instruction, pc} to decode.
// Latency : grant in t, rvalid in t+1 -> inst_valid in t+2; next request the cycle after accept.
// Backpressure: holds the word (no new imem request) while inst_ready=0; one request outstanding max.
module instruction_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter logic [DATA_WIDTH-1:0] NOP_INST   = 'h13
) (
    input  logic                  clk,
    input  logic                  rst_n,

    // PC redirect from the control unit (branch / jump taken)
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,

    // instruction memory port
    output logic                  imem_req,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic                  imem_gnt,
    input  logic                  imem_rvalid,
    input  logic [DATA_WIDTH-1:0] imem_rdata,

    // decode-side handshake
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] instruction,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [ADDR_WIDTH-1:0] pc_plus4
);

    // FETCH: request in flight on the bus, WAIT: granted, awaiting rvalid,
    // HOLD: word presented to decode, waiting for inst_ready.
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(4);

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   fetch_pc;      // address of the next / current fetch
    logic                    kill;          // the outstanding response belongs to a redirected-away path
    logic                    inst_valid_q;
    logic [DATA_WIDTH-1:0]   inst_q;
    logic [ADDR_WIDTH-1:0]   pc_q;
    logic [ADDR_WIDTH-1:0]   redirect_target;

    // Instructions are word aligned; low address bits of a target are dropped.
    assign redirect_target = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};

    // Fetch sequencer: PC update, outstanding-request tracking and the decode-side output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_FETCH;
            fetch_pc     <= RESET_PC;
            kill         <= 1'b0;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_INST;
            pc_q         <= RESET_PC;
        end else begin
            // A redirect always retargets the fetch PC; the last one seen wins.
            // The HOLD accept path below overrides this only when no redirect is present.
            if (redirect_valid) begin
                fetch_pc <= redirect_target;
            end

            case (state)
                S_FETCH: begin
                    if (imem_gnt) begin
                        // A redirect in the grant cycle makes the granted word stale.
                        state <= S_WAIT;
                        kill  <= redirect_valid;
                    end
                end

                S_WAIT: begin
                    if (imem_rvalid) begin
                        kill <= 1'b0;
                        if (kill || redirect_valid) begin
                            // Wrong-path word: drop it and fetch from the (new) target.
                            state <= S_FETCH;
                        end else begin
                            inst_q       <= imem_rdata;
                            pc_q         <= fetch_pc;
                            inst_valid_q <= 1'b1;
                            state        <= S_HOLD;
                        end
                    end else if (redirect_valid) begin
                        // Response still in flight; remember to discard it when it lands.
                        kill <= 1'b1;
                    end
                end

                S_HOLD: begin
                    if (redirect_valid) begin
                        // Flush: the held word is withdrawn (or was just consumed) and replaced by a NOP.
                        inst_valid_q <= 1'b0;
                        inst_q       <= NOP_INST;
                        state        <= S_FETCH;
                    end else if (inst_ready) begin
                        inst_valid_q <= 1'b0;
                        fetch_pc     <= pc_q + PC_STEP;
                        state        <= S_FETCH;
                    end
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

    // Memory request is a decode of the state, forced low while reset is asserted.
    assign imem_req    = rst_n && (state == S_FETCH);
    assign imem_addr   = fetch_pc;

    assign inst_valid  = inst_valid_q;
    assign instruction = inst_q;
    assign pc          = pc_q;
    // Wraps modulo 2^ADDR_WIDTH by construction.
    assign pc_plus4    = pc_q + PC_STEP;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP  = 32'h13;
    localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- DUT 1 : default RESET_PC ----------------
    logic        rst_n, redirect_valid, imem_req, imem_gnt, imem_rvalid;
    logic        inst_valid, inst_ready;
    logic [31:0] redirect_pc, imem_addr, imem_rdata, instruction, pc, pc_plus4;

    instruction_fetch_unit dut (
        .clk(clk), .rst_n(rst_n),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .inst_valid(inst_valid), .inst_ready(inst_ready),
        .instruction(instruction), .pc(pc), .pc_plus4(pc_plus4)
    );

    // ---------------- DUT 2 : RESET_PC at the top of the address space ----------------
    logic        rst2_n, redirect_valid2, imem_req2, imem_gnt2, imem_rvalid2;
    logic        inst_valid2, inst_ready2;
    logic [31:0] redirect_pc2, imem_addr2, imem_rdata2, instruction2, pc2, pc_plus4_2;

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst_n(rst2_n),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt2),
        .imem_rvalid(imem_rvalid2), .imem_rdata(imem_rdata2),
        .inst_valid(inst_valid2), .inst_ready(inst_ready2),
        .instruction(instruction2), .pc(pc2), .pc_plus4(pc_plus4_2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- directed cycle table ----------------
    typedef struct {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        ready;
        logic        rd_vld;
        logic [31:0] rd_pc;
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_valid;
        logic        chk_inst;
        logic [31:0] e_inst;
        logic [31:0] e_pc;
    } vec_t;

    localparam int NV = 29;
    vec_t tbl [NV];

    function automatic vec_t mk(input logic g, input logic rv, input logic [31:0] rd, input logic rdy,
                                input logic rdv, input logic [31:0] rdpc,
                                input logic er, input logic [31:0] ea, input logic ev,
                                input logic ci, input logic [31:0] ei, input logic [31:0] ep);
        vec_t v;
        v.gnt = g; v.rvalid = rv; v.rdata = rd; v.ready = rdy; v.rd_vld = rdv; v.rd_pc = rdpc;
        v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.chk_inst = ci; v.e_inst = ei; v.e_pc = ep;
        return v;
    endfunction

    // random-phase model state
    logic [31:0] exp_pc, exp_word, pend_data;
    logic        have_word, had_word, expect_nop, pending, stale, resp;
    int          wait_cnt, accepts, acc_tbl, seen_dead;

    initial begin
        //          gnt rv rdata         rdy rdv rd_pc       | req addr         vld ci inst          pc
        tbl[0]  = mk(1, 0, 32'h0,        0,  0,  32'h0,        1, 32'h0,        0,  1, NOP,          32'h0);
        tbl[1]  = mk(0, 1, 32'h1000_00A0,0,  0,  32'h0,        0, 32'h0,        0,  1, NOP,          32'h0);
        tbl[2]  = mk(0, 0, 32'h0,        1,  0,  32'h0,        0, 32'h0,        1,  1, 32'h1000_00A0,32'h0);
        tbl[3]  = mk(1, 0, 32'h0,        0,  0,  32'h0,        1, 32'h4,        0,  0, 32'h0,        32'h0);
        tbl[4]  = mk(0, 1, 32'h1000_00A4,0,  0,  32'h0,        0, 32'h0,        0,  0, 32'h0,        32'h0);
        tbl[5]  = mk(0, 0, 32'h0,        1,  0,  32'h0,        0, 32'h0,        1,  1, 32'h1000_00A4,32'h4);
        tbl[6]  = mk(1, 0, 32'h0,        0,  0,  32'h0,        1, 32'h8,        0,  0, 32'h0,        32'h0);
        tbl[7]  = mk(0, 1, 32'h1000_00A8,0,  0,  32'h0,        0, 32'h0,        0,  0, 32'h0,        32'h0);
        for (int i = 8; i <= 12; i++)
            tbl[i] = mk(0, 0, 32'h0,     0,  0,  32'h0,        0, 32'h0,        1,  1, 32'h1000_00A8,32'h8);
        tbl[13] = mk(0, 0, 32'h0,        1,  0,  32'h0,        0, 32'h0,        1,  1, 32'h1000_00A8,32'h8);
        tbl[14] = mk(1, 0, 32'h0,        0,  0,  32'h0,        1, 32'hC,        0,  0, 32'h0,        32'h0);
        tbl[15] = mk(0, 0, 32'h0,        0,  1,  32'h103,      0, 32'h0,        0,  0, 32'h0,        32'h0);
        tbl[16] = mk(0, 0, 32'h0,        0,  0,  32'h0,        0, 32'h0,        0,  0, 32'h0,        32'h0);
        tbl[17] = mk(0, 1, DEAD,         0,  0,  32'h0,        0, 32'h0,        0,  0, 32'h0,        32'h0);
        tbl[18] = mk(1, 0, 32'h0,        0,  0,  32'h0,        1, 32'h100,      0,  0, 32'h0,        32'h0);
        tbl[19] = mk(0, 1, 32'h2000_0100,0,  0,  32'h0,        0, 32'h0,        0,  0, 32'h0,        32'h0);
        tbl[20] = mk(0, 0, 32'h0,        1,  1,  32'h200,      0, 32'h0,        1,  1, 32'h2000_0100,32'h100);
        tbl[21] = mk(1, 0, 32'h0,        0,  1,  32'h300,      1, 32'h200,      0,  1, NOP,          32'h0);
        tbl[22] = mk(0, 1, 32'h1111_1111,0,  0,  32'h0,        0, 32'h0,        0,  1, NOP,          32'h0);
        tbl[23] = mk(0, 0, 32'h0,        0,  1,  32'h406,      1, 32'h300,      0,  0, 32'h0,        32'h0);
        tbl[24] = mk(1, 0, 32'h0,        0,  0,  32'h0,        1, 32'h404,      0,  0, 32'h0,        32'h0);
        tbl[25] = mk(0, 1, 32'h3000_0404,0,  0,  32'h0,        0, 32'h0,        0,  0, 32'h0,        32'h0);
        tbl[26] = mk(0, 0, 32'h0,        0,  1,  32'h500,      0, 32'h0,        1,  1, 32'h3000_0404,32'h404);
        tbl[27] = mk(0, 0, 32'h0,        0,  0,  32'h0,        1, 32'h500,      0,  1, NOP,          32'h0);
        tbl[28] = mk(0, 0, 32'h0,        0,  0,  32'h0,        1, 32'h500,      0,  0, 32'h0,        32'h0);

        // idle inputs, both DUTs in reset
        rst_n = 0; redirect_valid = 0; redirect_pc = 0; imem_gnt = 0; imem_rvalid = 0;
        imem_rdata = 0; inst_ready = 0;
        rst2_n = 0; redirect_valid2 = 0; redirect_pc2 = 0; imem_gnt2 = 0; imem_rvalid2 = 0;
        imem_rdata2 = 0; inst_ready2 = 0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst imem_req", imem_req, 0);
        check("rst inst_valid", inst_valid, 0);
        check("rst instruction", instruction, NOP);
        check("rst pc", pc, 32'h0);
        check("rst pc_plus4", pc_plus4, 32'h4);
        rst_n = 1;

        // ---- directed table: streaming, backpressure, redirects in WAIT/HOLD/FETCH ----
        acc_tbl = 0; seen_dead = 0;
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            check($sformatf("row%0d imem_req", i), imem_req, tbl[i].e_req);
            if (tbl[i].e_req) check($sformatf("row%0d imem_addr", i), imem_addr, tbl[i].e_addr);
            check($sformatf("row%0d inst_valid", i), inst_valid, tbl[i].e_valid);
            if (tbl[i].chk_inst) check($sformatf("row%0d instruction", i), instruction, tbl[i].e_inst);
            if (tbl[i].e_valid || i == 0) begin
                check($sformatf("row%0d pc", i), pc, tbl[i].e_pc);
                check($sformatf("row%0d pc_plus4", i), pc_plus4, tbl[i].e_pc + 32'd4);
            end
            if (inst_valid && tbl[i].ready) acc_tbl++;
            if (inst_valid && instruction == DEAD) seen_dead++;
            imem_gnt = tbl[i].gnt; imem_rvalid = tbl[i].rvalid; imem_rdata = tbl[i].rdata;
            inst_ready = tbl[i].ready; redirect_valid = tbl[i].rd_vld; redirect_pc = tbl[i].rd_pc;
        end
        @(negedge clk);
        imem_gnt = 0; imem_rvalid = 0; inst_ready = 0; redirect_valid = 0;
        check("table accept count", acc_tbl, 4);
        check("stale word delivered", seen_dead, 0);

        // ---- randomized run against a transaction-level model ----
        rst_n = 0;
        @(negedge clk);
        rst_n = 1;
        exp_pc = 32'h0; have_word = 0; expect_nop = 0; pending = 0; stale = 0;
        wait_cnt = 0; accepts = 0; exp_word = 0; pend_data = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            // compare DUT state against the model
            if (pending) check("rand one outstanding", imem_req, 0);
            check("rand inst_valid", inst_valid, have_word);
            if (have_word) begin
                check("rand instruction", instruction, exp_word);
                check("rand pc", pc, exp_pc);
                check("rand pc_plus4", pc_plus4, exp_pc + 32'd4);
            end
            if (expect_nop) begin
                check("rand flush nop", instruction, NOP);
                expect_nop = 0;
            end
            // memory response
            imem_rvalid = 0; imem_rdata = $urandom;
            resp = 0;
            if (pending) begin
                if (wait_cnt == 0) begin
                    imem_rvalid = 1; imem_rdata = pend_data; resp = 1;
                end else begin
                    wait_cnt--;
                end
            end
            imem_gnt = imem_req && !pending && ($urandom_range(0, 99) < 60);
            inst_ready = ($urandom_range(0, 99) < 60);
            redirect_valid = ($urandom_range(0, 99) < 8);
            redirect_pc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                       : 32'($urandom_range(0, 4095));
            // model update for this cycle's inputs
            had_word = have_word;
            if (have_word && inst_ready) begin
                have_word = 0;
                exp_pc = exp_pc + 32'd4;
                accepts++;
            end
            if (imem_gnt) begin
                check("rand fetch addr", imem_addr, exp_pc);
                pending = 1; stale = 0;
                pend_data = $urandom;
                wait_cnt = $urandom_range(0, 2);
            end
            if (redirect_valid) begin
                if (had_word) expect_nop = 1;
                have_word = 0;
                if (pending) stale = 1;
                exp_pc = redirect_pc & 32'hFFFF_FFFC;
            end
            if (resp) begin
                pending = 0;
                if (!stale) begin
                    have_word = 1;
                    exp_word = imem_rdata;
                end
            end
        end
        @(negedge clk);
        imem_gnt = 0; imem_rvalid = 0; inst_ready = 0; redirect_valid = 0;
        check("rand progress", (accepts > 100) ? 1 : 0, 1);

        // ---- wrap at top of address space, async reset ----
        @(negedge clk);
        check("wrap rst pc", pc2, 32'hFFFF_FFFC);
        check("wrap rst pc_plus4", pc_plus4_2, 32'h0);
        check("wrap rst imem_req", imem_req2, 0);
        rst2_n = 1;
        @(negedge clk);
        check("wrap req0", imem_req2, 1);
        check("wrap addr0", imem_addr2, 32'hFFFF_FFFC);
        imem_gnt2 = 1;
        @(negedge clk);
        imem_gnt2 = 0; imem_rvalid2 = 1; imem_rdata2 = 32'h0000_0777;
        @(negedge clk);
        imem_rvalid2 = 0;
        check("wrap valid", inst_valid2, 1);
        check("wrap inst", instruction2, 32'h0000_0777);
        check("wrap pc", pc2, 32'hFFFF_FFFC);
        check("wrap pc_plus4", pc_plus4_2, 32'h0);
        inst_ready2 = 1;
        @(negedge clk);
        inst_ready2 = 0;
        check("wrap req1", imem_req2, 1);
        check("wrap addr1", imem_addr2, 32'h0);
        imem_gnt2 = 1;
        @(negedge clk);
        imem_gnt2 = 0;               // now in WAIT
        #2 rst2_n = 0;
        #1;
        check("async rst req (wait)", imem_req2, 0);
        check("async rst valid (wait)", inst_valid2, 0);
        check("async rst pc (wait)", pc2, 32'hFFFF_FFFC);
        // async reset while a word is held
        @(negedge clk);
        rst2_n = 1;
        imem_gnt2 = 1;
        @(negedge clk);
        imem_gnt2 = 0; imem_rvalid2 = 1; imem_rdata2 = 32'h0000_0999;
        @(negedge clk);
        imem_rvalid2 = 0;
        check("hold valid before rst", inst_valid2, 1);
        #2 rst2_n = 0;
        #1;
        check("async rst valid (hold)", inst_valid2, 0);
        check("async rst inst (hold)", instruction2, NOP);
        check("async rst req (hold)", imem_req2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
